// File: rtl/pdm_sample_interp.sv
// pdm_sample_interp: sample FIFO plus linear interpolator feeding a PDM modulator.
// Each buffered sample becomes the ramp target for one 2**LOG2_DIV clk period.
// pdm_din moves from the previous target to the new one by a constant signed
// delta per clk. If the FIFO is empty at a period boundary, the output holds
// its value and underrun pulses.
module pdm_sample_interp #(
    parameter int NBITS    = 16,
    parameter int LOG2_DIV = 8,
    parameter int LOG2_DEP = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NBITS-1:0]    s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [NBITS-1:0]    pdm_din,
    output logic                sample_tick,
    output logic                underrun,
    output logic [LOG2_DEP:0]   level
);

    localparam int                  ACC_W      = NBITS + LOG2_DIV;
    localparam int                  DEPTH      = 2 ** LOG2_DEP;
    localparam logic [NBITS-1:0]    MID        = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [LOG2_DIV-1:0] CNT_LAST   = '1;
    localparam logic [LOG2_DIV-1:0] CNT_ONE    = LOG2_DIV'(1);
    localparam logic [LOG2_DEP:0]   LVL_FULL   = (LOG2_DEP+1)'(DEPTH);
    localparam logic [LOG2_DEP:0]   LVL_ONE    = (LOG2_DEP+1)'(1);
    localparam logic [LOG2_DEP-1:0] PTR_ONE    = LOG2_DEP'(1);

    logic [LOG2_DIV-1:0]      tick_cnt;
    logic                     boundary;

    logic [NBITS-1:0]         mem [DEPTH];
    logic [LOG2_DEP-1:0]      wr_ptr;
    logic [LOG2_DEP-1:0]      rd_ptr;
    logic [LOG2_DEP:0]        level_next;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic [NBITS-1:0]         head;

    logic [ACC_W-1:0]         acc;
    logic signed [NBITS:0]    delta;
    logic signed [ACC_W-1:0]  delta_ext;
    logic [NBITS-1:0]         target;

    // The FIFO status depends only on registered state, so s_ready has no path from s_valid.
    assign s_ready    = (level != LVL_FULL);
    assign fifo_empty = (level == '0);
    assign boundary   = (tick_cnt == CNT_LAST);
    assign push       = s_valid && s_ready;
    // The pop uses the registered level, so a sample pushed on a boundary clk is not visible to that boundary.
    assign pop        = boundary && !fifo_empty;
    assign head       = mem[rd_ptr];
    // Sign-extend the delta to the accumulator width. Unsigned modular addition then handles both directions.
    assign delta_ext  = ACC_W'(delta);

    // Free-running period counter. Its last value marks the sample-period boundary.
    // NOTE: clocked state uses non-blocking (<=) so that every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_ONE;
        end
    end

    // Next FIFO occupancy. A simultaneous push and pop leaves the occupancy unchanged.
    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LVL_ONE;
        end else if (pop && !push) begin
            level_next = level - LVL_ONE;
        end
    end

    // FIFO storage array, write side only.
    // NOTE: the storage array is not reset; emptiness is tracked by level and the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers and occupancy. Reset discards any buffered samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level <= level_next;
        end
    end

    // Interpolator: ramp the accumulator by delta, then snap it exactly onto the target at each boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= {MID, {LOG2_DIV{1'b0}}};
            delta  <= '0;
            target <= MID;
        end else if (boundary) begin
            acc <= {target, {LOG2_DIV{1'b0}}};
            if (pop) begin
                delta  <= $signed({1'b0, head}) - $signed({1'b0, target});
                target <= head;
            end else begin
                delta  <= '0;
            end
        end else begin
            acc <= acc + $unsigned(delta_ext);
        end
    end

    // Registered outputs: the integer part of acc, plus one-clk boundary and underrun pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pdm_din     <= MID;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            pdm_din     <= acc[ACC_W-1:LOG2_DIV];
            sample_tick <= boundary;
            underrun    <= boundary && fifo_empty;
        end
    end

endmodule
